// File: rtl/mem_port_arbiter_if.sv
// Controller-side bus of mem_port_arbiter: request pulses plus held
// address/data/mask toward the cache controller, status and read data back.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int STATE_WIDTH = 7
);
  logic                   rd_en;
  logic                   wr_en;
  logic [ADDR_WIDTH-1:0]  addr;
  logic [31:0]            wdata;
  logic [3:0]             mask;
  logic [31:0]            rdata;
  logic                   busy;
  logic [STATE_WIDTH-1:0] state;

  modport master (
    output rd_en, wr_en, addr, wdata, mask,
    input  rdata, busy, state
  );

  modport slave (
    input  rd_en, wr_en, addr, wdata, mask,
    output rdata, busy, state
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter/sequencer in front of the write-through cache controller.
// Define ARB_ROUND_ROBIN_EN for round-robin tie breaking; default is port 1 priority.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int STATE_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  rst_x,
  input  logic                  p0_req_i,
  input  logic [ADDR_WIDTH-1:0] p0_addr_i,
  output logic                  p0_ack_o,
  output logic [31:0]           p0_rdata_o,
  input  logic                  p1_req_i,
  input  logic                  p1_we_i,
  input  logic [ADDR_WIDTH-1:0] p1_addr_i,
  input  logic [31:0]           p1_wdata_i,
  input  logic [3:0]            p1_mask_i,
  output logic                  p1_ack_o,
  output logic [31:0]           p1_rdata_o,
  mem_port_arbiter_if.master    ctrl,
  output logic                  grant_o,
  output logic                  active_o
);

  localparam logic [STATE_WIDTH-1:0] CtrlIdle = '0;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

  state_e                state_q;
  logic                  grant_q;
  logic                  isWrite_q;
  logic                  rdEn_q;
  logic                  wrEn_q;
  logic                  active_q;
  logic                  p0Ack_q;
  logic                  p1Ack_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [3:0]            mask_q;
  logic [31:0]           p0Rdata_q;
  logic [31:0]           p1Rdata_q;

  logic anyReq;
  logic grant_d;
  logic isWrite_d;
  logic complete;

  assign anyReq = p0_req_i | p1_req_i;

`ifdef ARB_ROUND_ROBIN_EN
  logic lastServed_q;

  // On a tie the port that was not served last wins.
  always_comb begin
    grant_d = p1_req_i;
    if (p0_req_i && p1_req_i) begin
      grant_d = ~lastServed_q;
    end
  end

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      lastServed_q <= 1'b0;
    end else if (state_q == IDLE && anyReq) begin
      lastServed_q <= grant_d;
    end
  end
`else
  assign grant_d = p1_req_i;
`endif

  assign isWrite_d = grant_d & p1_we_i;

  // Reads finish on busy dropping; writes finish once the controller FSM is idle.
  assign complete = isWrite_q ? (ctrl.state == CtrlIdle) : ~ctrl.busy;

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      state_q   <= IDLE;
      grant_q   <= 1'b0;
      isWrite_q <= 1'b0;
      rdEn_q    <= 1'b0;
      wrEn_q    <= 1'b0;
      active_q  <= 1'b0;
      p0Ack_q   <= 1'b0;
      p1Ack_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      mask_q    <= '0;
      p0Rdata_q <= '0;
      p1Rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (anyReq) begin
            grant_q   <= grant_d;
            isWrite_q <= isWrite_d;
            addr_q    <= grant_d ? p1_addr_i : p0_addr_i;
            wdata_q   <= grant_d ? p1_wdata_i : 32'h0;
            mask_q    <= grant_d ? p1_mask_i : 4'hF;
            rdEn_q    <= ~isWrite_d;
            wrEn_q    <= isWrite_d;
            active_q  <= 1'b1;
            state_q   <= ISSUE;
          end
        end
        ISSUE: begin
          rdEn_q  <= 1'b0;
          wrEn_q  <= 1'b0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (complete) begin
            if (!isWrite_q) begin
              if (grant_q) p1Rdata_q <= ctrl.rdata;
              else         p0Rdata_q <= ctrl.rdata;
            end
            p0Ack_q <= ~grant_q;
            p1Ack_q <= grant_q;
            state_q <= DONE;
          end
        end
        DONE: begin
          p0Ack_q  <= 1'b0;
          p1Ack_q  <= 1'b0;
          active_q <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ctrl.rd_en = rdEn_q;
  assign ctrl.wr_en = wrEn_q;
  assign ctrl.addr  = addr_q;
  assign ctrl.wdata = wdata_q;
  assign ctrl.mask  = mask_q;
  assign p0_ack_o   = p0Ack_q;
  assign p1_ack_o   = p1Ack_q;
  assign p0_rdata_o = p0Rdata_q;
  assign p1_rdata_o = p1Rdata_q;
  assign grant_o    = grant_q;
  assign active_o   = active_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a behavioural cache controller model.
// Honours ARB_ROUND_ROBIN_EN when predicting tie winners.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int SW = 7;

  logic        clk = 1'b0;
  logic        rst_x = 1'b0;
  logic        p0_req, p1_req, p1_we;
  logic [31:0] p0_addr, p1_addr, p1_wdata;
  logic [3:0]  p1_mask;
  logic        p0_ack, p1_ack, grant, active;
  logic [31:0] p0_rdata, p1_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_WIDTH(AW), .STATE_WIDTH(SW)) ctrlBus ();

  mem_port_arbiter #(.ADDR_WIDTH(AW), .STATE_WIDTH(SW)) dut (
    .clk        (clk),
    .rst_x      (rst_x),
    .p0_req_i   (p0_req),
    .p0_addr_i  (p0_addr),
    .p0_ack_o   (p0_ack),
    .p0_rdata_o (p0_rdata),
    .p1_req_i   (p1_req),
    .p1_we_i    (p1_we),
    .p1_addr_i  (p1_addr),
    .p1_wdata_i (p1_wdata),
    .p1_mask_i  (p1_mask),
    .p1_ack_o   (p1_ack),
    .p1_rdata_o (p1_rdata),
    .ctrl       (ctrlBus),
    .grant_o    (grant),
    .active_o   (active)
  );

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic [31:0] rdata;
    int          lat;
  } exp_t;

  exp_t        expQ[$];
  exp_t        held;
  int          checkCount = 0;
  int          passCount = 0;
  int          cycle = 0;
  logic        inTxn = 1'b0;
  logic        prevPulse = 1'b0;
  int          lastPulseCycle = -100;
  int          lastAckCycle = -100;
  logic        sawAck0 = 1'b0;
  logic        sawAck1 = 1'b0;
  logic        pulseGrant = 1'b0;
  logic [31:0] p0Model = '0;
  logic [31:0] p1Model = '0;
  logic        rrLast = 1'b0;

  int          busyCycles = 0;
  logic [6:0]  stateSeq[$];
  int          ctlMode = 0;
  int          ctlCount = 0;
  logic [31:0] ctlData = '0;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
  endtask

  // Backing memory of the controller model; the two named words come from the test plan.
  function automatic logic [31:0] memFn(input logic [31:0] a);
    case (a)
      32'h100: memFn = 32'hDEADBEEF;
      32'h180: memFn = 32'hCAFEF00D;
      default: memFn = {~a[15:0], a[15:0]};
    endcase
  endfunction

  function automatic int zeroIndex();
    for (int i = 0; i < stateSeq.size(); i++) begin
      if (stateSeq[i] == 7'd0) return i;
    end
    return stateSeq.size();
  endfunction

  function automatic logic tieWinner();
`ifdef ARB_ROUND_ROBIN_EN
    return ~rrLast;
`else
    return 1'b1;
`endif
  endfunction

  task automatic driveReq(input logic port, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] mask);
    if (port) begin
      p1_req = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wdata; p1_mask = mask;
    end else begin
      p0_req = 1'b1; p0_addr = addr;
    end
  endtask

  task automatic expectTxn(input logic port, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] mask);
    exp_t e;
    e.port  = port;
    e.we    = port & we;
    e.addr  = addr;
    e.wdata = port ? wdata : 32'h0;
    e.mask  = port ? mask : 4'hF;
    e.rdata = e.we ? p1Model : memFn(addr);
    e.lat   = e.we ? zeroIndex() + 2 : busyCycles + 2;
    expQ.push_back(e);
    rrLast  = port;
  endtask

  task automatic applyStimulus(input logic port, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] mask);
    expectTxn(port, we, addr, wdata, mask);
    driveReq(port, we, addr, wdata, mask);
  endtask

  task automatic releaseReq(input logic port);
    if (port) p1_req = 1'b0;
    else      p0_req = 1'b0;
  endtask

  task automatic monitorOutputs();
    logic pulse;
    pulse   = ctrlBus.rd_en | ctrlBus.wr_en;
    sawAck0 = p0_ack;
    sawAck1 = p1_ack;
    if (pulse) begin
      checkOutput("pulseInTxn", inTxn, 0);
      checkOutput("pulseWidth", prevPulse, 0);
      checkOutput("pulseQueued", expQ.size() != 0, 1);
      if (expQ.size() != 0) begin
        held = expQ[0];
        checkOutput("pulseType", {ctrlBus.rd_en, ctrlBus.wr_en}, held.we ? 2'b01 : 2'b10);
        checkOutput("grant", grant, held.port);
        checkOutput("mAddr", ctrlBus.addr, held.addr);
        checkOutput("mWdata", ctrlBus.wdata, held.wdata);
        checkOutput("mMask", ctrlBus.mask, held.mask);
        checkOutput("activeIssue", active, 1);
      end
      pulseGrant     = grant;
      inTxn          = 1'b1;
      lastPulseCycle = cycle;
    end else if (inTxn) begin
      checkOutput("holdAddr", ctrlBus.addr, held.addr);
      checkOutput("holdWdata", ctrlBus.wdata, held.wdata);
      checkOutput("holdMask", ctrlBus.mask, held.mask);
      checkOutput("holdGrant", grant, held.port);
      checkOutput("activeTxn", active, 1);
    end else begin
      checkOutput("activeIdle", active, 0);
    end
    if (p0_ack || p1_ack) begin
      checkOutput("ackInTxn", inTxn, 1);
      checkOutput("ackPort", {p1_ack, p0_ack}, held.port ? 2'b10 : 2'b01);
      checkOutput("ackLatency", cycle - lastPulseCycle, held.lat);
      if (held.port) begin
        if (!held.we) p1Model = held.rdata;
      end else begin
        p0Model = held.rdata;
      end
      if (expQ.size() != 0) void'(expQ.pop_front());
      inTxn        = 1'b0;
      lastAckCycle = cycle;
    end
    checkOutput("p0Rdata", p0_rdata, p0Model);
    checkOutput("p1Rdata", p1_rdata, p1Model);
    prevPulse = pulse;
  endtask

  // Controller model: reads stay busy for busyCycles WAIT cycles, writes walk stateSeq.
  task automatic controllerModel();
    if (ctrlBus.rd_en) begin
      ctlMode = 1; ctlCount = 0; ctlData = memFn(ctrlBus.addr);
      ctrlBus.busy = 1'b1; ctrlBus.state = 7'd0; ctrlBus.rdata = 32'hBAD0BAD0;
    end else if (ctrlBus.wr_en) begin
      ctlMode = 2; ctlCount = 0;
      ctrlBus.busy = 1'b0; ctrlBus.state = 7'd5; ctrlBus.rdata = 32'hBAD0BAD0;
    end else if (ctlMode == 1) begin
      ctrlBus.state = 7'd0;
      if (ctlCount < busyCycles) begin
        ctrlBus.busy = 1'b1; ctrlBus.rdata = 32'hBAD0BAD0;
      end else begin
        ctrlBus.busy = 1'b0; ctrlBus.rdata = ctlData; ctlMode = 0;
      end
      ctlCount++;
    end else if (ctlMode == 2) begin
      ctrlBus.busy  = 1'b0;
      ctrlBus.rdata = 32'hBAD0BAD0;
      ctrlBus.state = (ctlCount < stateSeq.size()) ? stateSeq[ctlCount] : 7'd0;
      if (ctrlBus.state == 7'd0) ctlMode = 0;
      ctlCount++;
    end else begin
      ctrlBus.busy = 1'b0; ctrlBus.state = 7'd0; ctrlBus.rdata = 32'h600D0000 ^ cycle;
    end
  endtask

  task automatic step();
    @(negedge clk);
    cycle++;
    monitorOutputs();
    controllerModel();
  endtask

  task automatic runUntilAck(input logic port, input int budget);
    int   n = 0;
    logic got = 1'b0;
    while (!got && n < budget) begin
      step();
      n++;
      got = port ? sawAck1 : sawAck0;
    end
    if (!got) checkOutput(port ? "ackTimeoutP1" : "ackTimeoutP0", got, 1);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "P0Ack"}, p0_ack, 0);
    checkOutput({tag, "P1Ack"}, p1_ack, 0);
    checkOutput({tag, "P0Rdata"}, p0_rdata, 0);
    checkOutput({tag, "P1Rdata"}, p1_rdata, 0);
    checkOutput({tag, "RdEn"}, ctrlBus.rd_en, 0);
    checkOutput({tag, "WrEn"}, ctrlBus.wr_en, 0);
    checkOutput({tag, "Addr"}, ctrlBus.addr, 0);
    checkOutput({tag, "Wdata"}, ctrlBus.wdata, 0);
    checkOutput({tag, "Mask"}, ctrlBus.mask, 0);
    checkOutput({tag, "Grant"}, grant, 0);
    checkOutput({tag, "Active"}, active, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          reqCycle;
    int          firstPulse;
    logic [31:0] p0a, p1a;
    logic [3:0]  grantSeq;
    logic        w;

    p0_req = 1'b0; p0_addr = '0;
    p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0; p1_mask = '0;
    ctrlBus.busy = 1'b0; ctrlBus.state = '0; ctrlBus.rdata = '0;

    @(negedge clk);
    checkResetValues("reset");
    rst_x = 1'b1;
    repeat (2) step();

    $display("[TB] port 0 read hit");
    busyCycles = 0;
    applyStimulus(1'b0, 1'b0, 32'h100, 32'h0, 4'h0);
    reqCycle = cycle;
    runUntilAck(1'b0, 20);
    checkOutput("hitPulseAt", lastPulseCycle - reqCycle, 1);
    checkOutput("hitAckAt", lastAckCycle - reqCycle, 3);
    checkOutput("hitRdata", p0_rdata, 32'hDEADBEEF);
    releaseReq(1'b0);
    repeat (2) step();

    $display("[TB] port 1 write");
    stateSeq = '{7'd5, 7'd5, 7'd6, 7'd6, 7'd0};
    applyStimulus(1'b1, 1'b1, 32'h200, 32'h12345678, 4'b0011);
    runUntilAck(1'b1, 30);
    checkOutput("writeP1Rdata", p1_rdata, 32'h0);
    releaseReq(1'b1);
    repeat (2) step();

    $display("[TB] port 0 read miss");
    busyCycles = 10;
    applyStimulus(1'b0, 1'b0, 32'h180, 32'h0, 4'h0);
    runUntilAck(1'b0, 40);
    checkOutput("missRdata", p0_rdata, 32'hCAFEF00D);
    releaseReq(1'b0);
    busyCycles = 0;
    repeat (4) step();

    $display("[TB] new request during ack cycle");
    applyStimulus(1'b1, 1'b0, 32'h280, 32'h0, 4'hC);
    runUntilAck(1'b1, 20);
    firstPulse = lastPulseCycle;
    applyStimulus(1'b1, 1'b0, 32'h300, 32'h0, 4'hC);
    runUntilAck(1'b1, 20);
    checkOutput("b2bSpacing", lastPulseCycle - firstPulse, 4);
    releaseReq(1'b1);
    repeat (2) step();

    $display("[TB] reset during WAIT");
    busyCycles = 5;
    applyStimulus(1'b0, 1'b0, 32'h1C0, 32'h0, 4'h0);
    repeat (3) step();
    rst_x = 1'b0;
    p0_req = 1'b0;
    expQ.delete();
    inTxn = 1'b0; prevPulse = 1'b0; ctlMode = 0;
    ctrlBus.busy = 1'b0; ctrlBus.state = '0;
    p0Model = '0; p1Model = '0; rrLast = 1'b0;
    #1;
    checkResetValues("midReset");
    step();
    rst_x = 1'b1;
    busyCycles = 0;
    repeat (4) step();

    $display("[TB] both ports requesting");
    p0a = 32'h400;
    p1a = 32'h500;
    grantSeq = '0;
    driveReq(1'b0, 1'b0, p0a, 32'h0, 4'h0);
    driveReq(1'b1, 1'b0, p1a, 32'h0, 4'b1010);
    for (int t = 0; t < 4; t++) begin
      w = tieWinner();
      expectTxn(w, 1'b0, w ? p1a : p0a, 32'h0, 4'b1010);
      runUntilAck(w, 20);
      grantSeq = {grantSeq[2:0], pulseGrant};
      if (w) begin p1a = p1a + 32'h4; p1_addr = p1a; end
      else   begin p0a = p0a + 32'h4; p0_addr = p0a; end
    end
    releaseReq(1'b0);
    releaseReq(1'b1);
`ifdef ARB_ROUND_ROBIN_EN
    checkOutput("tieGrants", grantSeq, 4'b1010);
`else
    checkOutput("tieGrants", grantSeq, 4'b1111);
`endif
    repeat (3) step();

    $display("[TB] single request after tie traffic");
    applyStimulus(1'b1, 1'b0, 32'h340, 32'h0, 4'h3);
    runUntilAck(1'b1, 20);
    releaseReq(1'b1);
    repeat (3) step();
    checkOutput("scoreboardEmpty", expQ.size(), 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-port arbiter and sequencer in front of the SDRAM-backed write-through cache controller. Port 0 (instruction fetch, read-only) and port 1 (data, read/write with byte mask) share the controller's single user interface. The block serialises requests, issues one-cycle request pulses, holds address/data/mask stable for the whole transaction, detects completion from the controller's busy and state outputs, and returns a registered acknowledge with read data.

## Interface
- ADDR_WIDTH, 32, width of requester and controller addresses
- STATE_WIDTH, 7, width of controller state input

- clk  in  1  system clock, same clock as the cache controller
- rst_x  in  1  asynchronous, active-low reset
- p0_req  in  1  port 0 read request, level, held until p0_ack
- p0_addr  in  ADDR_WIDTH  port 0 address, stable while p0_req
- p0_ack  out  1  one-cycle pulse; p0_rdata valid in the same cycle
- p0_rdata  out  32  port 0 read data, registered
- p1_req  in  1  port 1 request, level, held until p1_ack
- p1_we  in  1  1 = write, 0 = read; stable while p1_req
- p1_addr  in  ADDR_WIDTH  port 1 address
- p1_wdata  in  32  port 1 write data
- p1_mask  in  4  port 1 byte mask
- p1_ack  out  1  one-cycle pulse; p1_rdata valid for reads
- p1_rdata  out  32  port 1 read data, registered
- m_rd_en  out  1  controller read pulse
- m_wr_en  out  1  controller write pulse
- m_addr  out  ADDR_WIDTH  controller address, registered, held for the transaction
- m_wdata  out  32  controller write data, held for the transaction
- m_mask  out  4  controller mask, held for the transaction; 4'hF for port 0
- m_rdata  in  32  controller read data
- m_busy  in  1  controller busy
- m_state  in  STATE_WIDTH  controller state; 0 = idle
- o_grant  out  1  port owning the current or last transaction
- o_active  out  1  high from ISSUE through DONE

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT, DONE.
- IDLE
  - If any req is high, arbitrate and register m_addr, m_wdata and m_mask from the winner.
  - Set o_grant and the operation type, then go to ISSUE.
  - If no req is high, stay in IDLE.
- ISSUE
  - Drive m_rd_en (read) or m_wr_en (write) high for exactly this cycle, then go to WAIT.
- WAIT
  - A read completes in the first WAIT cycle with m_busy==0.
  - A write completes in the first WAIT cycle with m_state==0.
  - On completion, capture m_rdata into the granted port's rdata register (reads only) and go to DONE.
- DONE
  - Pulse the granted port's ack for exactly this cycle, then go to IDLE.
  - req inputs are ignored in DONE.
- The requester must deassert req, or present a new request, at the clock edge ending its ack cycle.
- Arbitration: port 1 wins ties; port 0 is served only when p1_req is low.
- The rdata of the non-granted port is unchanged. Write transactions leave p1_rdata unchanged.
- m_addr, m_wdata and m_mask never change from ISSUE through DONE. The controller's mask path is combinational into the DRAM side, so this hold is mandatory.

## Timing
- Reset values:
  - state IDLE
  - all acks 0
  - m_rd_en 0, m_wr_en 0
  - m_addr 0, m_wdata 0, m_mask 0
  - p0_rdata 0, p1_rdata 0
  - o_grant 0, o_active 0
- All outputs are registered.
- Request sampled in IDLE at cycle N:
  - pulse in cycle N+1
  - first completion check in N+2
  - ack in the cycle after completion
- Minimum latency, req to ack, is 3 cycles (cache read hit: completion in N+2, ack in N+3).
- A read miss or a write completes at K ≥ N+2 and acks at K+1.
- Back-to-back throughput is at most one transaction every 4 cycles. A request held through DONE is re-arbitrated in the following IDLE.
- A req that drops before ack is a protocol violation; the transaction still completes and acks.
- Reset mid-transaction aborts immediately: no ack and no further pulses. The controller shares rst_x.

## Configuration
- ARB_ROUND_ROBIN_EN defined:
  - Add a one-bit last-served pointer, reset value 0 (last-served = port 0).
  - On a tie, grant the port not served last.
  - Update the pointer on each entry to ISSUE.
  - Net effect: port 1 wins the first tie after reset, then grants alternate.
- Not defined: fixed priority, with port 1 winning every tie. No pointer register is present.

## Test plan
- Port 0 read, addr 0x100, controller hits (m_busy 0 in the cycle after the pulse, m_rdata 0xDEADBEEF) -> m_rd_en in N+1 only, p0_ack in N+3, p0_rdata 0xDEADBEEF, m_mask 4'hF.
- Port 1 write, addr 0x200, data 0x12345678, mask 4'b0011, m_state 5,5,6,6,0 -> one m_wr_en pulse, address/data/mask held throughout, p1_ack the cycle after m_state==0, p1_rdata unchanged.
- Read miss with m_busy high for 10 WAIT cycles, data 0xCAFEF00D -> no ack during busy, p0_ack exactly once, p0_rdata 0xCAFEF00D.
- Both ports requesting continuously for 4 transactions:
  - Without the macro: all grants to port 1 while p1_req is held.
  - With ARB_ROUND_ROBIN_EN: grants 1,0,1,0.
- rst_x low for 1 cycle during WAIT -> all outputs return to reset values, no ack, next request after reset is served normally.
- p1 ack cycle with a new p1_req (read, 0x300) presented -> DONE ignores it, IDLE samples it, second m_rd_en 4 cycles after the first.
